// File: rtl/inverse_top.sv
// inverse_top: per-frequency complex reciprocal engine.
// For each start, the engine reads the PER_FREQ samples a of one frequency bin.
// It writes 1/a = conj(a)/|a|^2 in Q(FRAC_BITS) fixed point to the result BRAM.
// Optional macro INVERSE_ROUND_EN: when defined, quotients are rounded half away
// from zero. When undefined (the default), quotients are truncated toward zero.
module inverse_top #(
    parameter int DATA_WIDTH         = 16,
    parameter int MIC_NUM            = 8,
    parameter int SOR_NUM            = 2,
    parameter int FREQ_NUM           = 257,
    parameter int BRAM_RD_ADDR_WIDTH = 32,
    parameter int BRAM_RD_ADDR_BASE  = 0,
    parameter int BRAM_RD_INCREASE   = 2,
    parameter int BRAM_WR_ADDR_WIDTH = 32,
    parameter int BRAM_WR_ADDR_BASE  = 0,
    parameter int BRAM_WR_INCREASE   = 6,
    parameter int BRAM_WR_WE_WIDTH   = 6,
    parameter int RD_LATENCY         = 3,
    parameter int FRAC_BITS          = 30
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic signed [DATA_WIDTH-1:0]         af_bram_rd_real,
    input  logic signed [DATA_WIDTH-1:0]         af_bram_rd_imag,
    output logic                                 done,
    output logic                                 all_freq_finish,
    output logic        [BRAM_RD_ADDR_WIDTH-1:0] bram_rd_addr,
    output logic signed [3*DATA_WIDTH-1:0]       result_bram_wr_real,
    output logic signed [3*DATA_WIDTH-1:0]       result_bram_wr_imag,
    output logic        [BRAM_WR_ADDR_WIDTH-1:0] bram_wr_addr,
    output logic        [BRAM_WR_WE_WIDTH-1:0]   bram_wr_we,
    output logic                                 bram_wr_en
);
    localparam int PER_FREQ = MIC_NUM * SOR_NUM;
    localparam int DIVW     = DATA_WIDTH + FRAC_BITS;   // dividend bits = divide cycles
    localparam int RESW     = 3 * DATA_WIDTH;
    localparam int FW       = $clog2(FREQ_NUM + 1);
    localparam int KW       = $clog2(PER_FREQ + 1);
    localparam int CW       = $clog2(DIVW + RD_LATENCY + 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_MAG, S_DIV, S_WRITE, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic        [FW-1:0]           f;
    logic        [KW-1:0]           k;
    logic        [CW-1:0]           cnt;
    logic signed [DATA_WIDTH-1:0]   ar, ai;
    logic        [31:0]             den;
    logic        [1:0][31:0]        rem, rem_nx;
    logic        [1:0][DIVW-1:0]    dq, q_nx;
    logic        [1:0]              neg;
    logic        [RESW-1:0]         res_re, res_im;
    logic                           afin_q;

    wire last_k = (k == KW'(PER_FREQ - 1));
    wire last_f = (f == FW'(FREQ_NUM - 1));

    // Element index n = f*PER_FREQ + k drives both byte addresses.
    logic [31:0] n;
    assign n            = 32'(f) * 32'(PER_FREQ) + 32'(k);
    assign bram_rd_addr = BRAM_RD_ADDR_WIDTH'(32'(BRAM_RD_ADDR_BASE) + n * 32'(BRAM_RD_INCREASE));
    assign bram_wr_addr = BRAM_WR_ADDR_WIDTH'(32'(BRAM_WR_ADDR_BASE) + n * 32'(BRAM_WR_INCREASE));

    assign result_bram_wr_real = res_re;
    assign result_bram_wr_imag = res_im;
    assign all_freq_finish     = afin_q | (done & last_f);

    // |a|^2 and operand magnitudes, evaluated in MAG from the captured sample.
    logic signed [31:0]       ar_w, ai_w;
    logic        [31:0]       den_c;
    logic [DATA_WIDTH-1:0]    mag_r, mag_i;
    logic [1:0][DIVW-1:0]     dvd0;
    assign ar_w  = 32'(ar);
    assign ai_w  = 32'(ai);
    assign den_c = $unsigned(ar_w * ar_w) + $unsigned(ai_w * ai_w);
    assign mag_r = ar[DATA_WIDTH-1] ? (~ar) + DATA_WIDTH'(1) : ar;
    assign mag_i = ai[DATA_WIDTH-1] ? (~ai) + DATA_WIDTH'(1) : ai;
`ifdef INVERSE_ROUND_EN
    assign dvd0[0] = {mag_r, {FRAC_BITS{1'b0}}} + DIVW'(den_c >> 1);
    assign dvd0[1] = {mag_i, {FRAC_BITS{1'b0}}} + DIVW'(den_c >> 1);
`else
    assign dvd0[0] = {mag_r, {FRAC_BITS{1'b0}}};
    assign dvd0[1] = {mag_i, {FRAC_BITS{1'b0}}};
`endif

    // One restoring-divider step per lane: shift in a dividend bit, subtract when it fits.
    for (genvar i = 0; i < 2; i++) begin : g_div
        logic [32:0] rem_sh, diff;
        logic        ge;
        assign rem_sh    = {rem[i], dq[i][DIVW-1]};
        assign diff      = rem_sh - {1'b0, den};
        assign ge        = (rem_sh >= {1'b0, den});
        assign rem_nx[i] = ge ? diff[31:0] : rem_sh[31:0];
        assign q_nx[i]   = {dq[i][DIVW-2:0], ge};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;

    // Next state and per-state strobes.
    always_comb begin
        state_d    = state_q;
        done       = 1'b0;
        bram_wr_en = 1'b0;
        bram_wr_we = '0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  state_d = S_WAIT;
            S_WAIT:  if (cnt == CW'(RD_LATENCY - 1)) state_d = S_MAG;
            S_MAG:   state_d = S_DIV;
            S_DIV:   if (cnt == CW'(DIVW - 1)) state_d = S_WRITE;
            S_WRITE: begin
                bram_wr_en = 1'b1;
                bram_wr_we = '1;
                state_d    = last_k ? S_DONE : S_READ;
            end
            S_DONE:  begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture, divider iteration, result and index bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            f      <= '0;
            k      <= '0;
            ar     <= '0;
            ai     <= '0;
            den    <= '0;
            rem    <= '0;
            dq     <= '0;
            neg    <= '0;
            res_re <= '0;
            res_im <= '0;
            afin_q <= 1'b0;
        end else begin
            cnt <= (state_d != state_q) ? '0 : cnt + CW'(1);
            case (state_q)
                S_IDLE:  if (start) afin_q <= 1'b0;
                S_WAIT:  if (cnt == CW'(RD_LATENCY - 1)) begin
                    ar <= af_bram_rd_real;
                    ai <= af_bram_rd_imag;
                end
                S_MAG: begin
                    den    <= den_c;
                    dq     <= dvd0;
                    rem    <= '0;
                    neg[0] <= ar[DATA_WIDTH-1];
                    neg[1] <= ~ai[DATA_WIDTH-1] & (ai != '0);   // sign of -ai
                end
                S_DIV: begin
                    rem <= rem_nx;
                    dq  <= q_nx;
                    if (cnt == CW'(DIVW - 1)) begin
                        if (den == '0) begin
                            res_re <= '0;
                            res_im <= '0;
                        end else begin
                            res_re <= neg[0] ? RESW'(0) - RESW'(q_nx[0]) : RESW'(q_nx[0]);
                            res_im <= neg[1] ? RESW'(0) - RESW'(q_nx[1]) : RESW'(q_nx[1]);
                        end
                    end
                end
                S_WRITE: k <= last_k ? '0 : k + KW'(1);
                S_DONE: begin
                    f <= last_f ? '0 : f + FW'(1);
                    if (last_f) afin_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inverse_top.sv
// Self-checking bench for inverse_top. It uses a behavioural BRAM with read
// latency and a reference model that does plain 64-bit division.
// FREQ_NUM is reduced so that a full frequency wrap fits in the cycle budget.
module tb_inverse_top;
    localparam int FN  = 33;
    localparam int PF  = 16;
    localparam int TOT = FN * PF;
    localparam longint ONE30 = 64'sd1073741824;

    logic               clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic signed [15:0] rd_re, rd_im;
    logic               done, all_freq_finish, bram_wr_en;
    logic [31:0]        bram_rd_addr, bram_wr_addr;
    logic signed [47:0] res_re, res_im;
    logic [5:0]         bram_wr_we;

    inverse_top #(.FREQ_NUM(FN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .af_bram_rd_real(rd_re), .af_bram_rd_imag(rd_im),
        .done(done), .all_freq_finish(all_freq_finish),
        .bram_rd_addr(bram_rd_addr),
        .result_bram_wr_real(res_re), .result_bram_wr_imag(res_im),
        .bram_wr_addr(bram_wr_addr), .bram_wr_we(bram_wr_we), .bram_wr_en(bram_wr_en)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference: 1/a = conj(a)/|a|^2, truncated toward zero; 0 for a = 0.
    function automatic void ref_inv(input logic signed [15:0] a, input logic signed [15:0] b,
                                    output longint r, output longint i);
        longint d;
        d = longint'(a) * longint'(a) + longint'(b) * longint'(b);
        if (d == 0) begin
            r = 0;
            i = 0;
        end else begin
            r = (longint'(a) * ONE30) / d;
            i = (-longint'(b) * ONE30) / d;
        end
    endfunction

    // Sample memory and a three-stage read pipeline.
    logic signed [15:0] mre [TOT];
    logic signed [15:0] mim [TOT];
    logic signed [15:0] pre [3];
    logic signed [15:0] pim [3];
    int idx;
    assign idx   = (int'(bram_rd_addr) / 2 < TOT) ? int'(bram_rd_addr) / 2 : 0;
    assign rd_re = pre[2];
    assign rd_im = pim[2];
    always @(posedge clk) begin
        pre[0] <= mre[idx]; pre[1] <= pre[0]; pre[2] <= pre[1];
        pim[0] <= mim[idx]; pim[1] <= pim[0]; pim[2] <= pim[1];
    end

    // Write monitor: in-order addresses, data against the model.
    int     hits [TOT];
    int     n_wr = 0, n_done = 0, exp_n = 0;
    longint er, ei;
    always @(negedge clk) begin
        if (!rst_n) exp_n = 0;
        else begin
            if (done) n_done++;
            if (bram_wr_en) begin
                ref_inv(mre[exp_n], mim[exp_n], er, ei);
                chk("wr_addr", longint'(bram_wr_addr), longint'(exp_n * 6));
                chk("wr_we", longint'(bram_wr_we), 63);
                chk("wr_real", longint'(res_re), er);
                chk("wr_imag", longint'(res_im), ei);
                if (exp_n == 0) begin
                    chk("e0_real", longint'(res_re), -1075891);
                    chk("e0_imag", longint'(res_im), 1073739);
                end
                if (exp_n == 1) chk("e1_real", longint'(res_re), 1073741824);
                if (exp_n == 500) begin
                    chk("e500_addr", longint'(bram_wr_addr), 3000);
                    chk("e500_imag", longint'(res_im), -1073741824);
                end
                hits[exp_n]++;
                n_wr++;
                exp_n = (exp_n + 1) % TOT;
            end
        end
    end

    int f_mod = 0;

    task automatic run_freq(input bit poke);
        int  w0, d0, lat;
        bit  got;
        w0 = n_wr;
        d0 = n_done;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (c == 1) chk("afin_clr", longint'(all_freq_finish), 0);
            start = poke && (c == 200);
            if (done) begin
                lat = c;
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", longint'(got), 1);
        chk("done_lat", lat, 833);
        chk("afin_rise", longint'(all_freq_finish), longint'(f_mod == FN - 1));
        @(negedge clk);
        chk("done_pulse", longint'(done), 0);
        chk("n_wr", n_wr - w0, 16);
        chk("n_done", n_done - d0, 1);
        f_mod = (f_mod + 1) % FN;
        chk("rd_addr_next", longint'(bram_rd_addr), longint'(f_mod * PF * 2));
        chk("afin_hold", longint'(all_freq_finish), longint'(f_mod == 0));
    endtask

    initial begin
        int bad, w0, d0;
        for (int i = 0; i < TOT; i++) begin
            if (i % 4 == 0) begin
                mre[i] = 16'($signed($urandom_range(8)) - 4);
                mim[i] = 16'($signed($urandom_range(8)) - 4);
            end else begin
                mre[i] = 16'($urandom);
                mim[i] = 16'($urandom);
            end
            hits[i] = 0;
        end
        mre[0] = -16'sd500;  mim[0] = -16'sd499;
        mre[1] = 16'sd1;     mim[1] = 16'sd0;
        mre[2] = 16'sd0;     mim[2] = 16'sd0;
        mre[3] = -16'sd32768; mim[3] = -16'sd32768;
        mre[5] = -16'sd32768; mim[5] = 16'sd0;
        mre[500] = 16'sd0;   mim[500] = 16'sd1;

        repeat (3) @(negedge clk);
        chk("rst_rd_addr", longint'(bram_rd_addr), 0);
        chk("rst_wr_addr", longint'(bram_wr_addr), 0);
        chk("rst_real", longint'(res_re), 0);
        chk("rst_imag", longint'(res_im), 0);
        chk("rst_we", longint'(bram_wr_we), 0);
        chk("rst_en", longint'(bram_wr_en), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_afin", longint'(all_freq_finish), 0);
        rst_n = 1'b1;

        // First round: freq 0 with a stray start while busy, then the rest.
        run_freq(1'b1);
        for (int f = 1; f < FN; f++) run_freq(1'b0);
        bad = 0;
        for (int i = 0; i < TOT; i++) if (hits[i] != 1) bad++;
        chk("write_once", bad, 0);

        // Second round restarts at address 0.
        run_freq(1'b0);

        // Reset during element 7 aborts; the next start redoes frequency 0.
        w0 = n_wr;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 2000 && (n_wr - w0) < 7; c++) @(negedge clk);
        chk("abort_pre_wr", n_wr - w0, 7);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rd_addr", longint'(bram_rd_addr), 0);
        chk("abort_en", longint'(bram_wr_en), 0);
        chk("abort_done", longint'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        w0 = n_wr;
        d0 = n_done;
        repeat (100) @(negedge clk);
        chk("abort_no_wr", n_wr - w0, 0);
        chk("abort_no_done", n_done - d0, 0);
        f_mod = 0;
        run_freq(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
